// File: rtl/data_mem_ctrl.sv
// Byte/halfword/word data memory for the RV32I MEM stage, with a req/ready
// handshake and a programmable number of wait states before each access completes.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   function automatic logic [DEPTH_WORDS-1:0][31:0] f_init();
      logic [DEPTH_WORDS-1:0][31:0] v;
      for (int k = 0; k < DEPTH_WORDS; k++) v[k] = 32'(DEPTH_WORDS - 1 - k);
      return v;
   endfunction

   // Power-up image: word k holds DEPTH_WORDS-1-k; reset never touches it.
   logic [DEPTH_WORDS-1:0][31:0] r_mem = f_init();

   state_t      r_state, w_next;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_addr, r_wdata;

   logic        w_commit, w_we, w_rej;
   logic [2:0]  w_f3;
   logic [31:0] w_a, w_wdata, w_word, w_load, w_wd;
   logic [AW-1:0] w_idx;
   logic [1:0]  w_off;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [3:0]  w_be;
   logic        w_unused;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
         S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

   // With zero wait states the commit edge is the capture edge, so use the live inputs.
   assign w_we    = (r_state == S_IDLE) ? we     : r_we;
   assign w_f3    = (r_state == S_IDLE) ? funct3 : r_f3;
   assign w_a     = (r_state == S_IDLE) ? addr   : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? wdata  : r_wdata;

   assign w_idx    = w_a[AW+1:2];
   assign w_off    = w_a[1:0];
   assign w_word   = r_mem[w_idx];
   assign w_byte   = w_word[{w_off, 3'b000} +: 8];
   assign w_half   = w_word[{w_a[1], 4'b0000} +: 16];
   assign w_unused = &{1'b0, w_a[31:AW+2]};

   always_comb begin
      w_rej = 1'b1;
      case (w_f3)
         3'b000:  w_rej = 1'b0;
         3'b001:  w_rej = w_a[0];
         3'b010:  w_rej = |w_a[1:0];
         3'b100:  w_rej = w_we;
         3'b101:  w_rej = w_we | w_a[0];
         default: w_rej = 1'b1;
      endcase
   end

   always_comb begin
      w_load = w_word;
      case (w_f3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'h0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = w_word;
      endcase
   end

   // Replicate store data across lanes; the byte enables pick the live lanes.
   always_comb begin
      w_be = 4'b1111;
      w_wd = w_wdata;
      case (w_f3[1:0])
         2'b00: begin
            w_be = 4'b0001 << w_off;
            w_wd = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be = w_a[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be = 4'b1111;
            w_wd = w_wdata;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_we       <= 1'b0;
         r_f3       <= 3'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         rdata      <= 32'd0;
         misaligned <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && req) begin
            r_we    <= we;
            r_f3    <= funct3;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
         end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit) begin
            rdata      <= (w_rej || w_we) ? 32'd0 : w_load;
            misaligned <= w_rej;
            if (w_we && !w_rej)
               for (int b = 0; b < 4; b++)
                  if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
         end
      end
   end

   assign ready = (r_state == S_RESP);
   assign busy  = (r_state != S_IDLE);
endmodule
